// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field bundles into I/S/B/R words and
// streams them with sequential word addresses into instruction memory.
module instr_encoder #(
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [8:0]        word_count
);

    localparam int          IDX_W   = $clog2(MAX_WORDS + 1);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [6:0]  OP_LOAD = 7'b0000011;
    localparam logic [6:0]  OP_IMM  = 7'b0010011;
    localparam logic [6:0]  OP_ST   = 7'b0100011;
    localparam logic [6:0]  OP_BR   = 7'b1100011;
    localparam logic [6:0]  OP_REG  = 7'b0110011;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] addr_next;
    logic              accept;
    logic              handshake;
    logic              last_accept;
    logic              fits12;
    logic              fits13;
    logic [31:0]       enc_word;
    logic              enc_bad;

    // Sign-extension test: all bits above the field width match its MSB.
    assign fits12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign fits13 = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];

    always_comb begin
        enc_word = NOP;
        enc_bad  = 1'b0;
        unique case (in_opcode)
            OP_LOAD, OP_IMM: begin
                if (fits12)
                    enc_word = {in_imm[11:0], in_rs1, in_funct3,
                                in_rd, in_opcode};
                else
                    enc_bad = 1'b1;
            end
            OP_ST: begin
                if (fits12)
                    enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:0], in_opcode};
                else
                    enc_bad = 1'b1;
            end
            OP_BR: begin
                if (fits13)
                    enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                                in_funct3, in_imm[4:1], in_imm[11],
                                in_opcode};
                else
                    enc_bad = 1'b1;
            end
            OP_REG: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3,
                            in_rd, in_opcode};
            end
            default: enc_bad = 1'b1;
        endcase
    end

    assign in_ready    = (state == RUN) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign handshake   = out_valid && out_ready;
    assign last_accept = in_last || (idx == IDX_W'(MAX_WORDS - 1));
    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_addr   <= BASE;
            addr_next  <= BASE;
            idx        <= '0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            if (handshake)
                word_count <= word_count + 9'd1;

            // Accept and drain in one cycle simply overwrite the register.
            if (accept) begin
                out_valid <= 1'b1;
                out_instr <= enc_word;
                out_addr  <= addr_next;
                addr_next <= addr_next + STEP;
                idx       <= idx + IDX_W'(1);
                if (enc_bad)
                    err <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        idx        <= '0;
                        addr_next  <= BASE;
                        err        <= 1'b0;
                        word_count <= '0;
                    end
                end
                RUN: begin
                    if (accept && last_accept)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (handshake)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
